// File: rtl/axi_stream_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI4-Stream header+pixel filter
// between N_SRC sources, with pixel-count checking against the frame header.
module axi_stream_frame_arbiter #(
    parameter int N_SRC  = 2,
    parameter int DATA_W = 24,
    parameter int DIM_W  = 13,
    localparam int GW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [N_SRC-1:0]        s_tvalid_i,
    output logic [N_SRC-1:0]        s_tready_o,
    input  logic [N_SRC-1:0]        s_tlast_i,
    input  logic [N_SRC*DATA_W-1:0] s_tdata_i,
    output logic                    m_tvalid_o,
    input  logic                    m_tready_i,
    output logic                    m_tlast_o,
    output logic [DATA_W-1:0]       m_tdata_o,
    output logic [GW-1:0]           grant_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    len_err_o,
    output logic [15:0]             frame_cnt_o
);
    localparam int CW = GW + 1;
    localparam int EW = 2 * DIM_W;

    typedef enum logic [1:0] {IDLE, HDR_X, HDR_Y, PIX} state_t;

    state_t            state;
    logic [GW-1:0]     grant_q, last_grant, winner;
    logic              found;
    logic [CW-1:0]     cand;
    logic [DIM_W-1:0]  xsize;
    logic [EW-1:0]     expected, pix_cnt;
    logic              hdr_err, frame_done_q, len_err_q;
    logic [15:0]       frame_cnt_q;
    logic              busy, sel_valid, sel_last, xfer, frame_end;
    logic [DATA_W-1:0] sel_data;

    // Search begins one past the previous owner so every requester gets a turn.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = CW'(last_grant) + CW'(k);
            if (cand >= CW'(N_SRC)) cand = cand - CW'(N_SRC);
            if (!found && s_tvalid_i[cand[GW-1:0]]) begin
                found  = 1'b1;
                winner = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        sel_valid  = s_tvalid_i[grant_q];
        sel_last   = s_tlast_i[grant_q];
        sel_data   = s_tdata_i[grant_q*DATA_W +: DATA_W];
        m_tvalid_o = busy && sel_valid;
        m_tlast_o  = (state == PIX) && sel_last;
        m_tdata_o  = busy ? sel_data : '0;
        s_tready_o = '0;
        if (busy) s_tready_o[grant_q] = m_tready_i;
        xfer       = m_tvalid_o && m_tready_i;
        frame_end  = xfer && m_tlast_o;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            grant_q      <= '0;
            last_grant   <= GW'(N_SRC - 1);
            xsize        <= '0;
            expected     <= '0;
            pix_cnt      <= '0;
            hdr_err      <= 1'b0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= frame_end;
            len_err_q    <= frame_end && (((pix_cnt + EW'(1)) != expected) || hdr_err);
            frame_cnt_q  <= frame_cnt_q + 16'(frame_end);
            case (state)
                IDLE: if (found) begin
                    state      <= HDR_X;
                    grant_q    <= winner;
                    last_grant <= winner;
                    hdr_err    <= 1'b0;
                end
                HDR_X: if (xfer) begin
                    xsize   <= sel_data[DIM_W-1:0];
                    hdr_err <= hdr_err | sel_last;
                    state   <= HDR_Y;
                end
                // Product is taken from the live ysize word so it is ready for a 1-pixel frame.
                HDR_Y: if (xfer) begin
                    expected <= EW'(xsize) * EW'(sel_data[DIM_W-1:0]);
                    pix_cnt  <= '0;
                    hdr_err  <= hdr_err | sel_last;
                    state    <= PIX;
                end
                PIX: if (xfer) begin
                    pix_cnt <= pix_cnt + EW'(1);
                    if (sel_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grant_o      = grant_q;
    assign busy_o       = busy;
    assign frame_done_o = frame_done_q;
    assign len_err_o    = len_err_q;
    assign frame_cnt_o  = frame_cnt_q;
endmodule

// File: tb/tb_axi_stream_frame_arbiter.sv
// Bench for axi_stream_frame_arbiter: per-cycle vector tables plus a
// hand-written round-robin sequence with two always-requesting sources.
module tb_axi_stream_frame_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s_tvalid, s_tready, s_tlast;
    logic [47:0] s_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [23:0] m_tdata;
    logic [0:0]  grant;
    logic        busy, frame_done, len_err;
    logic [15:0] frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int vec_no = 0;

    axi_stream_frame_arbiter #(.N_SRC(2), .DATA_W(24), .DIM_W(13)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast), .m_tdata_o(m_tdata),
        .grant_o(grant), .busy_o(busy), .frame_done_o(frame_done), .len_err_o(len_err),
        .frame_cnt_o(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v, l;
        logic [23:0] d0, d1;
        logic        rdy;
        logic [47:0] exp;
    } vec_t;

    vec_t vq[$];

    // {m_tvalid, m_tlast, m_tdata, s_tready, busy, grant (only while busy), frame_done, len_err, frame_cnt}
    function automatic logic [47:0] pk(input logic ev, input logic el, input logic [23:0] ed,
                                       input logic [1:0] er, input logic eb, input logic eg,
                                       input logic edn, input logic ee, input logic [15:0] ec);
        return {ev, el, ed, er, eb, eb ? eg : 1'b0, edn, ee, ec};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input logic r, input logic [1:0] v, input logic [1:0] l,
                        input logic [23:0] d0, input logic [23:0] d1, input logic rdy,
                        input logic dn, input logic ee, input logic [15:0] cnt);
        vq.push_back('{r, v, l, d0, d1, rdy, pk(1'b0, 1'b0, 24'h0, 2'b00, 1'b0, 1'b0, dn, ee, cnt)});
    endtask

    task automatic act(input logic r, input logic [1:0] v, input logic [1:0] l,
                       input logic [23:0] d0, input logic [23:0] d1, input logic rdy,
                       input logic el, input logic [23:0] ed, input logic [1:0] er,
                       input logic g, input logic [15:0] cnt);
        vq.push_back('{r, v, l, d0, d1, rdy, pk(1'b1, el, ed, er, 1'b1, g, 1'b0, 1'b0, cnt)});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic run_vecs();
        foreach (vq[i]) begin
            rst_n    = vq[i].rst;
            s_tvalid = vq[i].v;
            s_tlast  = vq[i].l;
            s_tdata  = {vq[i].d1, vq[i].d0};
            m_tready = vq[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", vec_no),
                pk(m_tvalid, m_tlast, m_tdata, s_tready, busy, grant[0], frame_done, len_err, frame_cnt),
                vq[i].exp);
            vec_no++;
            tick();
        end
        vq.delete();
    endtask

    function automatic logic [23:0] word(input int src, input int w);
        return (w < 2) ? 24'd3 : 24'(src * 'h10000 + w);
    endfunction

    task automatic seq_round_robin();
        int w[2];
        int frames, words, idle_run;
        logic in_frame;
        logic [1:0] hs;
        logic exp_g[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n = 1'b0; s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = '0; m_tready = 1'b1;
        tick();
        rst_n = 1'b1;
        w[0] = 0; w[1] = 0; frames = 0; words = 0; idle_run = 0; in_frame = 1'b0;
        for (int cyc = 0; cyc < 200 && frames < 4; cyc++) begin
            s_tvalid = 2'b11;
            s_tlast  = {w[1] == 10, w[0] == 10};
            s_tdata  = {word(1, w[1]), word(0, w[0])};
            @(negedge clk);
            if (busy) begin
                if (!in_frame) begin
                    chk("rr_grant", 48'(grant), 48'(exp_g[frames]));
                    if (frames > 0) chk("rr_idle_gap", 48'(idle_run), 48'd1);
                    in_frame = 1'b1; words = 0; idle_run = 0;
                end
                chk("rr_nonowner_ready", 48'(s_tready[~grant[0]]), 48'd0);
                if (m_tvalid && m_tready) begin
                    chk("rr_word", {23'd0, m_tlast, m_tdata}, {23'd0, words == 10, word(int'(grant), words)});
                    words++;
                end
            end else begin
                idle_run++;
                if (frame_done) begin
                    chk("rr_frame_len", 48'(words), 48'd11);
                    frames++;
                    in_frame = 1'b0;
                end
            end
            hs = s_tvalid & s_tready;
            tick();
            for (int i = 0; i < 2; i++) if (hs[i]) w[i] = (w[i] == 10) ? 0 : w[i] + 1;
        end
        chk("rr_frames_done", 48'(frames), 48'd4);
    endtask

    initial begin
        rst_n = 1'b0; s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = '0; m_tready = 1'b1;
        tick(); tick();

        // Single 4x2 frame from source 0; first row is the reset state.
        idle(1, 2'b01, 2'b00, 24'd4, 0, 1, 0, 0, 16'd0);
        act (1, 2'b01, 2'b00, 24'd4, 0, 1, 0, 24'd4, 2'b01, 0, 16'd0);
        act (1, 2'b01, 2'b00, 24'd2, 0, 1, 0, 24'd2, 2'b01, 0, 16'd0);
        for (int p = 1; p <= 8; p++)
            act(1, 2'b01, (p == 8) ? 2'b01 : 2'b00, 24'h100 + 24'(p), 0, 1,
                p == 8, 24'h100 + 24'(p), 2'b01, 0, 16'd0);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 0, 16'd1);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 16'd1);

        // 2x2 frame from source 1 under alternating backpressure.
        idle(1, 2'b10, 2'b00, 0, 24'd2, 1, 0, 0, 16'd1);
        act (1, 2'b10, 2'b00, 0, 24'd2, 1, 0, 24'd2, 2'b10, 1, 16'd1);
        act (1, 2'b10, 2'b00, 0, 24'd2, 0, 0, 24'd2, 2'b00, 1, 16'd1);
        act (1, 2'b10, 2'b00, 0, 24'd2, 1, 0, 24'd2, 2'b10, 1, 16'd1);
        for (int q = 1; q <= 4; q++)
            for (int r = 0; r < 2; r++)
                act(1, 2'b10, (q == 4) ? 2'b10 : 2'b00, 0, 24'hA0 + 24'(q), r[0],
                    q == 4, 24'hA0 + 24'(q), r[0] ? 2'b10 : 2'b00, 1, 16'd1);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 0, 16'd2);

        // 3x3 header with tlast on pixel 7.
        idle(1, 2'b01, 2'b00, 24'd3, 0, 1, 0, 0, 16'd2);
        act (1, 2'b01, 2'b00, 24'd3, 0, 1, 0, 24'd3, 2'b01, 0, 16'd2);
        act (1, 2'b01, 2'b00, 24'd3, 0, 1, 0, 24'd3, 2'b01, 0, 16'd2);
        for (int p = 1; p <= 7; p++)
            act(1, 2'b01, (p == 7) ? 2'b01 : 2'b00, 24'h200 + 24'(p), 0, 1,
                p == 7, 24'h200 + 24'(p), 2'b01, 0, 16'd2);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 1, 16'd3);

        // xsize = 0: always a length error, still ends on tlast.
        idle(1, 2'b01, 2'b00, 24'd0, 0, 1, 0, 0, 16'd3);
        act (1, 2'b01, 2'b00, 24'd0, 0, 1, 0, 24'd0, 2'b01, 0, 16'd3);
        act (1, 2'b01, 2'b00, 24'd5, 0, 1, 0, 24'd5, 2'b01, 0, 16'd3);
        act (1, 2'b01, 2'b01, 24'hB1, 0, 1, 1, 24'hB1, 2'b01, 0, 16'd3);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 1, 16'd4);

        // 1x2 frame with a stray tlast on the ysize word.
        idle(1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 0, 16'd4);
        act (1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 24'd1, 2'b01, 0, 16'd4);
        act (1, 2'b01, 2'b01, 24'd2, 0, 1, 0, 24'd2, 2'b01, 0, 16'd4);
        act (1, 2'b01, 2'b00, 24'hC1, 0, 1, 0, 24'hC1, 2'b01, 0, 16'd4);
        act (1, 2'b01, 2'b01, 24'hC2, 0, 1, 1, 24'hC2, 2'b01, 0, 16'd4);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 1, 16'd5);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 16'd5);

        // Reset during pixels, then both sources request: source 0 wins.
        idle(1, 2'b01, 2'b00, 24'd4, 0, 1, 0, 0, 16'd5);
        act (1, 2'b01, 2'b00, 24'd4, 0, 1, 0, 24'd4, 2'b01, 0, 16'd5);
        act (1, 2'b01, 2'b00, 24'd2, 0, 1, 0, 24'd2, 2'b01, 0, 16'd5);
        act (1, 2'b01, 2'b00, 24'h101, 0, 1, 0, 24'h101, 2'b01, 0, 16'd5);
        act (1, 2'b01, 2'b00, 24'h102, 0, 1, 0, 24'h102, 2'b01, 0, 16'd5);
        act (0, 2'b11, 2'b00, 24'h103, 24'd4, 1, 0, 24'h103, 2'b01, 0, 16'd5);
        idle(1, 2'b11, 2'b00, 24'd4, 24'd4, 1, 0, 0, 16'd0);
        act (1, 2'b11, 2'b00, 24'd4, 24'd4, 1, 0, 24'd4, 2'b01, 0, 16'd0);
        run_vecs();

        seq_round_robin();

        // Counter wrap: preload near the top, then two back-to-back 1x1 frames.
        rst_n = 1'b0; s_tvalid = 2'b00; s_tlast = 2'b00; s_tdata = '0; m_tready = 1'b1;
        tick();
        rst_n = 1'b1;
        force dut.frame_cnt_q = 16'hFFFE;
        tick(); tick();
        release dut.frame_cnt_q;
        idle(1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 0, 16'hFFFE);
        act (1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 24'd1, 2'b01, 0, 16'hFFFE);
        act (1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 24'd1, 2'b01, 0, 16'hFFFE);
        act (1, 2'b01, 2'b01, 24'hD1, 0, 1, 1, 24'hD1, 2'b01, 0, 16'hFFFE);
        idle(1, 2'b01, 2'b00, 24'd1, 0, 1, 1, 0, 16'hFFFF);
        act (1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 24'd1, 2'b01, 0, 16'hFFFF);
        act (1, 2'b01, 2'b00, 24'd1, 0, 1, 0, 24'd1, 2'b01, 0, 16'hFFFF);
        act (1, 2'b01, 2'b01, 24'hD2, 0, 1, 1, 24'hD2, 2'b01, 0, 16'hFFFF);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 1, 0, 16'h0000);
        idle(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 16'h0000);
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
